// File: rtl/mul64_pkg.sv
// Shared definitions for the iterative 64-bit multiplier.
package mul64_pkg;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } mul_state_e;

    // Two's-complement negation of a full-width product.
    function automatic logic [2*WIDTH-1:0] neg128(input logic [2*WIDTH-1:0] x);
        return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/multiplier64_seq.sv
// Radix-2 shift-add multiplier: full 2*WIDTH-bit product, signed or unsigned,
// WIDTH steps plus one sign-fix cycle behind a start/busy/done handshake.
module multiplier64_seq
    import mul64_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic [WIDTH-1:0] prod_lo_o
);

    mul_state_e         state_q;
    logic [WIDTH:0]     acc_q;      // carry plus WIDTH bits
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;   // shifts right, collects the product low half
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   prod_hi_q;
    logic [WIDTH-1:0]   prod_lo_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   mplier_next;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fixed;

    // Operand magnitudes and one shift-add step of the datapath.
    always_comb begin
        // The most negative value maps onto itself, which is its correct unsigned magnitude.
        a_mag = (signed_op_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
        b_mag = (signed_op_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;

        addend      = mplier_q[0] ? {1'b0, mcand_q} : '0;
        sum         = acc_q + addend;
        acc_next    = {1'b0, sum[WIDTH:1]};
        mplier_next = {sum[0], mplier_q[WIDTH-1:1]};

        product       = {acc_q[WIDTH-1:0], mplier_q};
        product_fixed = neg_q ? neg128(product) : product;
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= signed_op_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    acc_q    <= acc_next;
                    mplier_q <= mplier_next;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    prod_hi_q <= product_fixed[2*WIDTH-1:WIDTH];
                    prod_lo_q <= product_fixed[WIDTH-1:0];
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign prod_hi_o = prod_hi_q;
    assign prod_lo_o = prod_lo_q;

endmodule

// File: tb/tb_multiplier64_seq.sv
// Scoreboard bench for multiplier64_seq against a plain-arithmetic product model.
module tb_multiplier64_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_op_i = 1'b0;
    logic [63:0] a_i = '0;
    logic [63:0] b_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [63:0] prod_hi_o;
    logic [63:0] prod_lo_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [127:0] prod;
        int           start_cyc;
    } exp_t;

    exp_t sb[$];

    multiplier64_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .signed_op_i (signed_op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .prod_hi_o   (prod_hi_o),
        .prod_lo_o   (prod_lo_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic s);
        logic signed [127:0] sa;
        logic signed [127:0] sb_v;
        logic [127:0] ua;
        logic [127:0] ub;
        if (s) begin
            sa   = $signed(a);
            sb_v = $signed(b);
            return sa * sb_v;
        end
        ua = {64'd0, a};
        ub = {64'd0, b};
        return ua * ub;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] b, input logic s);
        exp_t e;
        e.prod      = ref_mul(a, b, s);
        e.start_cyc = cyc;
        sb.push_back(e);
    endtask

    // Monitor: every done must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got=%h_%h expected=no_done", prod_hi_o, prod_lo_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", {prod_hi_o, prod_lo_o}, e.prod);
                check("latency", 128'(cyc - e.start_cyc), 128'd65);
                check("busy_at_done", {127'd0, busy_o}, 128'd0);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy_o; i++) begin
            @(posedge clk);
            #1;
        end
        if (busy_o) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got=busy expected=idle");
        end
    endtask

    // Issue one accepted operation; returns just after the start edge.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s);
        wait_idle();
        a_i         = a;
        b_i         = b;
        signed_op_i = s;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        push(a, b, s);
    endtask

    initial begin
        int n;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] corners[6];
        corners[0] = 64'h0;
        corners[1] = 64'h1;
        corners[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        corners[3] = 64'h8000_0000_0000_0000;
        corners[4] = 64'h7FFF_FFFF_FFFF_FFFF;
        corners[5] = 64'h0000_0001_0000_0000;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {62'd0, busy_o, done_o, prod_hi_o}, 128'd0);
        check("reset_lo", {64'd0, prod_lo_o}, 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 10*3 signed plus busy-length measurement
        run_op(64'd10, 64'd3, 1'b1);
        n = 0;
        while (busy_o && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("busy_cycles", 128'(n), 128'd65);
        check("direct_10x3", {prod_hi_o, prod_lo_o}, 128'd30);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_idle();
        check("direct_ffxff_signed", {prod_hi_o, prod_lo_o}, 128'd1);

        // start while busy is ignored; operand changes mid-run have no effect
        run_op(64'd7, 64'd6, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        a_i = 64'd5;
        b_i = 64'd5;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_idle();
        check("direct_7x6", {prod_hi_o, prod_lo_o}, 128'd42);

        // reset mid-operation aborts with no done
        run_op(64'd123, 64'd456, 1'b0);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy_done", {126'd0, busy_o, done_o}, 128'd0);
        check("abort_product", {prod_hi_o, prod_lo_o}, 128'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("abort_stays_idle", {126'd0, busy_o, done_o}, 128'd0);

        // back-to-back: start held through the done cycle
        a_i = 64'd100;
        b_i = 64'd100;
        signed_op_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        push(64'd100, 64'd100, 1'b0);
        a_i = 64'd3;
        b_i = 64'hFFFF_FFFF_FFFF_FFFC;
        signed_op_i = 1'b1;
        n = 0;
        while (!done_o && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("b2b_first", {prod_hi_o, prod_lo_o}, 128'd10000);
        @(posedge clk);
        #1;
        push(64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        start_i = 1'b0;
        wait_idle();
        check("b2b_second", {prod_hi_o, prod_lo_o},
              {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF4});

        // randomized operations, mixing corner values in
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) rb = corners[$urandom_range(0, 5)];
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end
        wait_idle();

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            n++;
            @(posedge clk);
        end
        check("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
